// File: rtl/float_pkg.sv
// Shared constants, flag positions and operand classification for the float add/sub pipeline.
package float_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // out_flags = {invalid, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } op_class_t;

  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < exp_w; i++) w[man_w+i] = 1'b1;
    w[man_w-1] = 1'b1;
    return w;
  endfunction

  function automatic logic [63:0] inf_mag_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < exp_w; i++) w[man_w+i] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero count; an all-zero vector returns W.
module lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) cnt = CW'(W-1-i);
    end
  end

endmodule

// File: rtl/float_addsub_pipe.sv
// IEEE-754 add/sub, flush-to-zero, RNE rounding; 3-stage pipeline, latency 3.
// Valid/ready at both ends: each stage advances when its successor is empty or advancing.
module float_addsub_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic [3:0]             out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW+1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [W-2:0]     INF_MAG  = (W-1)'(inf_mag_word(EXP_W, MAN_W));

  logic s1_vld, s2_vld, s3_vld;
  logic en1, en2, en3;

  assign en3       = !s3_vld || out_ready;
  assign en2       = !s2_vld || en3;
  assign en1       = !s1_vld || en2;
  assign in_ready  = en1;
  assign out_valid = s3_vld;

  // ---------------- S1: unpack / classify / swap / align ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb, ma_f, mb_f;
  op_class_t        ca, cb;
  logic             swap, res_sign, eff_sub;
  logic [EXP_W-1:0] big_e, small_e, d;
  logic [MAN_W:0]   big_sig, small_sig;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    aligned;
  logic             special;
  logic [W-1:0]     spec_val;
  logic [3:0]       spec_flags;

  assign ea = in_a[W-2:MAN_W];
  assign eb = in_b[W-2:MAN_W];
  assign ma = in_a[MAN_W-1:0];
  assign mb = in_b[MAN_W-1:0];

  assign ca = '{sign: in_a[W-1], is_zero: (ea == '0),
                is_inf: (ea == EXP_ONES) && (ma == '0),
                is_nan: (ea == EXP_ONES) && (ma != '0),
                is_snan: (ea == EXP_ONES) && (ma != '0) && !ma[MAN_W-1]};
  assign cb = '{sign: in_b[W-1] ^ in_sub, is_zero: (eb == '0),
                is_inf: (eb == EXP_ONES) && (mb == '0),
                is_nan: (eb == EXP_ONES) && (mb != '0),
                is_snan: (eb == EXP_ONES) && (mb != '0) && !mb[MAN_W-1]};

  assign ma_f = ca.is_zero ? '0 : ma;
  assign mb_f = cb.is_zero ? '0 : mb;

  always_comb begin
    swap      = {eb, mb_f} > {ea, ma_f};
    big_e     = swap ? eb : ea;
    small_e   = swap ? ea : eb;
    big_sig   = swap ? {!cb.is_zero, mb_f} : {!ca.is_zero, ma_f};
    small_sig = swap ? {!ca.is_zero, ma_f} : {!cb.is_zero, mb_f};
    res_sign  = swap ? cb.sign : ca.sign;
    eff_sub   = ca.sign ^ cb.sign;
    d         = big_e - small_e;
    wide      = {small_sig, 3'b000, {SW{1'b0}}} >> d;
    if (32'(d) >= 32'(MAN_W+3))
      aligned = {{(SW-1){1'b0}}, |small_sig};
    else
      aligned = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

    special    = 1'b0;
    spec_val   = QNAN;
    spec_flags = '0;
    if (ca.is_nan || cb.is_nan) begin
      special                  = 1'b1;
      spec_flags[FLAG_INVALID] = ca.is_snan || cb.is_snan;
    end else if (ca.is_inf && cb.is_inf && eff_sub) begin
      special                  = 1'b1;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (ca.is_inf) begin
      special  = 1'b1;
      spec_val = {ca.sign, INF_MAG};
    end else if (cb.is_inf) begin
      special  = 1'b1;
      spec_val = {cb.sign, INF_MAG};
    end
  end

  logic             s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_big, s1_small;
  logic [W-1:0]     s1_spec_val;
  logic [3:0]       s1_spec_flags;

  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_sign       <= res_sign;
      s1_sub        <= eff_sub;
      s1_exp        <= big_e;
      s1_big        <= {big_sig, 3'b000};
      s1_small      <= aligned;
      s1_spec       <= special;
      s1_spec_val   <= spec_val;
      s1_spec_flags <= spec_flags;
    end
  end

  // ---------------- S2: significand add / subtract ----------------
  logic [SW:0]   sum;
  logic [SW-1:0] man2;
  logic [EW-1:0] exp2;

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                 : ({1'b0, s1_big} + {1'b0, s1_small});
    if (sum[SW]) begin
      man2 = sum[SW:1] | {{(SW-1){1'b0}}, sum[0]};
      exp2 = EW'(s1_exp) + EW'(1);
    end else begin
      man2 = sum[SW-1:0];
      exp2 = EW'(s1_exp);
    end
  end

  logic             s2_sign, s2_sub, s2_spec;
  logic [EW-1:0]    s2_exp;
  logic [SW-1:0]    s2_man;
  logic [W-1:0]     s2_spec_val;
  logic [3:0]       s2_spec_flags;

  always_ff @(posedge clk) begin
    if (en2 && s1_vld) begin
      s2_sign       <= s1_sign;
      s2_sub        <= s1_sub;
      s2_exp        <= exp2;
      s2_man        <= man2;
      s2_spec       <= s1_spec;
      s2_spec_val   <= s1_spec_val;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic [CW-1:0]  lz;
  logic [SW-1:0]  norm;
  logic [EW-1:0]  exp_n, exp_r;
  logic [MAN_W+1:0] mant;
  logic           rnd_up;
  logic [W-1:0]   res;
  logic [3:0]     flags;

  lzc #(.W(SW)) u_lzc (.vec(s2_man), .cnt(lz));

  always_comb begin
    norm   = s2_man << lz;
    exp_n  = s2_exp - EW'(lz);
    rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant   = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    exp_r  = mant[MAN_W+1] ? exp_n + EW'(1) : exp_n;
    res    = {s2_sign, exp_r[EXP_W-1:0], mant[MAN_W-1:0]};
    flags  = '0;
    flags[FLAG_INEXACT] = |norm[2:0];
    if (s2_spec) begin
      res   = s2_spec_val;
      flags = s2_spec_flags;
    end else if (mant[MAN_W+1:MAN_W] == 2'b00) begin
      // no hidden bit after normalising means the significand was zero
      res   = {s2_sign & ~s2_sub, {(W-1){1'b0}}};
      flags = '0;
    end else if (exp_r[EW-1] || exp_r == '0) begin
      res                   = '0;
      flags                 = '0;
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else if (exp_r >= EW'(EXP_ONES)) begin
      res                  = {s2_sign, INF_MAG};
      flags                = '0;
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s3_vld    <= 1'b0;
      out_sum   <= '0;
      out_flags <= '0;
    end else begin
      if (en1) s1_vld <= in_valid;
      if (en2) s2_vld <= s1_vld;
      if (en3) begin
        s3_vld <= s2_vld;
        if (s2_vld) begin
          out_sum   <= res;
          out_flags <= flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed bench for float_addsub_pipe: single ops with latency, pipelined stall run, mid-flight reset.
module tb_float_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_sum;
  logic [3:0]  out_flags;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  float_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_flags(out_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents one op to an empty pipeline; checks latency, result and flags, then drains it.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp_sum, input logic [3:0] exp_flags);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_flg"}, {28'b0, out_flags}, {28'b0, exp_flags});
    @(posedge clk); #1;
  endtask

  logic [31:0] pa [8] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000,
                          32'h40400000, 32'h3F000000, 32'h40800000, 32'h3FC00000};
  logic [31:0] pb [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                          32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h3FC00000};
  logic        ps [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] pe [8] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'hBF800000,
                          32'h40800000, 32'h3F800000, 32'h40400000, 32'h40400000};

  int   sent, got;
  logic saw_full, seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_flags", {28'b0, out_flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    run_op("cancel",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_op("round_up",      32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0001);
    run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_op("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);
    run_op("neg_result",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    run_op("qnan_in",       32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run_op("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("inf_plus_fin",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    run_op("fin_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    run_op("denorm_in",     32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    run_op("underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    run_op("neg_zeros",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);

    // back-to-back ops against a consumer that stalls first, then toggles randomly
    sent = 0; got = 0; saw_full = 1'b0;
    out_ready = 1'b0;
    fork
      begin : prod
        int   pcyc;
        logic acc;
        pcyc = 0;
        while (sent < 8 && pcyc < 200) begin
          in_a = pa[sent]; in_b = pb[sent]; in_sub = ps[sent]; in_valid = 1'b1;
          @(negedge clk);
          acc = in_ready;
          if (!in_ready) saw_full = 1'b1;
          @(posedge clk); #1;
          if (acc) sent++;
          pcyc++;
        end
        in_valid = 1'b0;
      end
      begin : mon
        int          mcyc;
        logic        stall;
        logic [31:0] last_sum;
        logic [3:0]  last_flg;
        mcyc = 0; stall = 1'b0; last_sum = '0; last_flg = '0;
        while (got < 8 && mcyc < 200) begin
          @(negedge clk);
          if (stall) begin
            check("stall_sum", out_sum, last_sum);
            check("stall_flg", {28'b0, out_flags}, {28'b0, last_flg});
          end
          if (out_valid && out_ready) begin
            check("pipe_sum", out_sum, pe[got]);
            check("pipe_flg", {28'b0, out_flags}, 32'd0);
            got++;
          end
          stall    = out_valid && !out_ready;
          last_sum = out_sum;
          last_flg = out_flags;
          @(posedge clk); #2;
          mcyc++;
          out_ready = (mcyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    check("pipe_sent", 32'(sent), 32'd8);
    check("pipe_got", 32'(got), 32'd8);
    check("pipe_full", {31'b0, saw_full}, 32'd1);
    @(posedge clk); #1;

    // three ops in flight, then a one-cycle reset
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_a = 32'h40000000; in_b = 32'h3F800000; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_flush", {31'b0, seen}, 32'd0);
    run_op("post_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_addsub_pipe.md
FLOAT_ADDSUB_PIPE -- requirements
Module: float_addsub_pipe

Interface
REQ-001 The block SHALL take parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL take parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a  input  W  operand A, IEEE-754 layout.
REQ-008 in_b  input  W  operand B, IEEE-754 layout.
REQ-009 in_sub  input  1  0: A+B, 1: A-B (B sign inverted).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  W  result.
REQ-013 out_flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-014 The datapath SHALL be a 3-stage pipeline: S1 unpack/swap/align, S2 mantissa add/subtract, S3 normalise/round/pack; latency exactly 3 cycles with no stall.
REQ-015 Each stage SHALL hold a valid bit; a stage advances when its successor is empty or advancing; in_ready = !S1.valid or S1 advancing; S3 holds while out_valid && !out_ready.
REQ-016 out_sum and out_flags SHALL remain stable while out_valid && !out_ready; one transfer per in_valid&&in_ready, in order, none dropped or duplicated.
REQ-017 S1 SHALL order operands by magnitude (exp, then mantissa), larger becomes A'; result sign defaults to sign of A'.
REQ-018 S1 SHALL right-shift smaller significand by exponent difference into MAN_W+4-bit field keeping guard, round, sticky; differences >= MAN_W+3 collapse to sticky only.
REQ-019 Subnormal inputs (exp=0) SHALL be flushed to signed zero before alignment; subnormal results flushed to +0 with underflow=1, inexact=1.
REQ-020 S2 SHALL add when effective signs equal, else subtract smaller from larger; carry-out shifts right one place into sticky, exponent +1.
REQ-021 S3 SHALL left-normalise using a leading-zero count, rounding round-to-nearest-even on guard/round/sticky; mantissa rounding overflow SHALL renormalise (exp+1).
REQ-022 Exact cancellation (x - x) SHALL produce +0, flags 0.
REQ-023 Exponent reaching all-ones after normalise/round SHALL give signed infinity, overflow=1, inexact=1.
REQ-024 Any NaN input, or inf + (-inf) effective, SHALL give canonical qNaN (sign 0, exp all-ones, mantissa MSB only), invalid=1 for inf-inf or signalling NaN.
REQ-025 inf op finite SHALL return that infinity, flags 0; inexact=1 whenever any discarded bit nonzero.

Reset
REQ-026 While rst_n=0 at a rising edge all stage valid bits SHALL clear; out_valid=0, out_sum=0, out_flags=0 next cycle; in_ready=1 in the first cycle after reset release.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight results; no out_valid for pre-reset operands.

Structure
REQ-028 Package float_pkg SHALL hold defaults EXP_W/MAN_W, flag bit indices, qNaN/inf constant functions, and the unpacked-operand struct typedef.
REQ-029 Leading-zero count SHALL be one sub-module, lzc, parametrised on width, purely combinational.

Verification
REQ-030 0x3F800000 + 0x3F800000, in_sub=0 -> 0x40000000, flags 0, out_valid exactly 3 cycles after acceptance.
REQ-031 0x3F800000 - 0x3F800000 -> 0x00000000, flags 0; 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
REQ-032 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 inexact=1; 0x3F800000 + 0x34400000 -> 0x3F800002 inexact=1.
REQ-033 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
REQ-034 Back-to-back 8 operands with out_ready toggling random: in_ready drops when full, outputs in order, stable during stall.
REQ-035 rst_n low for 1 cycle with 3 ops in flight -> no out_valid for them; next op result correct at latency 3.
